// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder: access-size encodings,
// FSM states and the small legality helpers used by the lane aligner.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned CNT_W = 4;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_e;

  function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
    if (is_store) begin
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    end
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // funct3[1:0] encodes the access size for every legal code.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (f3[1:0])
      2'b01:   bad = addr_lo[0];
      2'b10:   bad = |addr_lo;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store byte-enables and write word, load extraction with
// sign/zero extension, and the illegal-funct3 / misalignment flag.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wword_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Store direction: replicate the narrow datum across the word, the enables pick the lanes.
  always_comb begin
    be_o    = 4'b1111;
    wword_o = wdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << addr_lo_i;
        wword_o = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wword_o = {2{wdata_i[15:0]}};
      end
      default: begin
        be_o    = 4'b1111;
        wword_o = wdata_i;
      end
    endcase
  end

  always_comb begin
    byte_sel = rword_i[7:0];
    case (addr_lo_i)
      2'b00:   byte_sel = rword_i[7:0];
      2'b01:   byte_sel = rword_i[15:8];
      2'b10:   byte_sel = rword_i[23:16];
      default: byte_sel = rword_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
  end

  always_comb begin
    rdata_o = rword_i;
    case (funct3_i)
      F3_B:    rdata_o = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    rdata_o = {{16{half_sel[15]}}, half_sel};
      F3_BU:   rdata_o = {24'h0, byte_sel};
      F3_HU:   rdata_o = {16'h0, half_sel};
      default: rdata_o = rword_i;
    endcase
  end

  assign err_o = !f3_legal(funct3_i, is_store_i) || misaligned(funct3_i, addr_lo_i);

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the core's load/store interface: word array with a fixed
// access latency, holding the core with stall_o until the commit cycle.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        access_err_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam cnt_t CNT_LOAD  = cnt_t'(LATENCY - 1);

  logic [31:0]   mem_q [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic [31:0]   rword;

  state_e        state_q, state_d;
  cnt_t          cnt_q, cnt_d;
  logic [31:0]   rdata_q;

  logic          is_store;
  logic          req_any;
  logic          lane_err;
  logic          legal_req;
  logic          commit;
  logic [3:0]    be;
  logic [31:0]   wword;
  logic [31:0]   load_data;
  logic          unused_addr_bits;

  // Upper address bits are deliberately ignored so accesses wrap modulo the array.
  assign idx              = addr_i[AW+1:2];
  assign unused_addr_bits = ^(addr_i >> (AW + 2));
  assign rword            = mem_q[idx];

  // Write wins over read; nothing is accepted while reset is asserted.
  assign is_store  = mem_write_i;
  assign req_any   = rst_ni & (mem_read_i | mem_write_i);
  assign legal_req = req_any & ~lane_err;

  dmem_lane_align u_lane_align (
    .is_store_i (is_store),
    .funct3_i   (funct3_i),
    .addr_lo_i  (addr_i[1:0]),
    .wdata_i    (wdata_i),
    .rword_i    (rword),
    .be_o       (be),
    .wword_o    (wword),
    .rdata_o    (load_data),
    .err_o      (lane_err)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (legal_req) begin
          cnt_d = CNT_LOAD;
          if (CNT_LOAD == cnt_t'(0)) begin
            state_d = S_DONE;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!legal_req) begin
          // Request withdrawn: abandon the access without committing anything.
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
          if (cnt_q == cnt_t'(1)) begin
            state_d = S_DONE;
            commit  = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (commit && !is_store) begin
        rdata_q <= load_data;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (commit && is_store) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem_q[idx][8*b +: 8] <= wword[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o      = rdata_q;
  assign stall_o      = legal_req & (state_q != S_DONE);
  assign access_err_o = req_any & lane_err;

endmodule
